// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM state type and address-field helpers for
// the L1 data cache (dcache_ctrl and cache_line_ram).
//   Byte address layout: [1:0] byte, [4:2] word offset, [4+INDEX_W:5] index,
//   [31:5+INDEX_W] tag. The 27-bit line address is byte address [31:5].
package cache_pkg;

    localparam int LINES       = 16;
    localparam int LINE_WORDS  = 8;
    localparam int WORD_W      = 32;
    localparam int LINE_W      = 256;
    localparam int OFF_W       = 3;
    localparam int BLK_W       = 5;
    localparam int LINE_ADDR_W = 32 - BLK_W;
    localparam int INDEX_W     = $clog2(LINES);
    localparam int TAG_W       = LINE_ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } dcache_state_t;

    // Word offset within the line.
    function automatic logic [OFF_W-1:0] addr_off(input logic [31:0] a);
        return a[4:2];
    endfunction

    // Line address as presented to the line adapter.
    function automatic logic [LINE_ADDR_W-1:0] addr_line(input logic [31:0] a);
        return a[31:5];
    endfunction

    // Set index for the default geometry.
    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
        return a[BLK_W +: INDEX_W];
    endfunction

    // Tag for the default geometry.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

endpackage

// File: rtl/cache_line_ram.sv
// cache_line_ram: LINES entries of {tag, valid, dirty, line data}.
//   Ports:
//     CLK, RST          clock; synchronous active-high reset (clears valid/dirty only)
//     rd_idx            asynchronous read index -> rd_valid, rd_dirty, rd_tag, rd_data
//     ww_en/idx/off/be/data   byte-enabled single-word store; marks the line dirty
//     lw_en/idx/tag/data      full-line install; sets valid, clears dirty, loads tag
//     dc_en/idx          clears the dirty bit after a victim write-back
//   Tag and data arrays are not reset.
module cache_line_ram
    import cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_B  = 23
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_B-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              ww_en,
    input  logic [IDX_W-1:0]  ww_idx,
    input  logic [OFF_W-1:0]  ww_off,
    input  logic [3:0]        ww_be,
    input  logic [WORD_W-1:0] ww_data,
    input  logic              lw_en,
    input  logic [IDX_W-1:0]  lw_idx,
    input  logic [TAG_B-1:0]  lw_tag,
    input  logic [LINE_W-1:0] lw_data,
    input  logic              dc_en,
    input  logic [IDX_W-1:0]  dc_idx
);

    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;
    logic [TAG_B-1:0]  tag_r  [LINES];
    logic [LINE_W-1:0] data_r [LINES];
    logic [WORD_W-1:0] old_word_s;
    logic [WORD_W-1:0] new_word_s;

    assign rd_valid = valid_r[rd_idx];
    assign rd_dirty = dirty_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

    // Merge the enabled store bytes into the currently held word.
    always_comb begin
        old_word_s = data_r[ww_idx][{ww_off, 5'd0} +: WORD_W];
        new_word_s = old_word_s;
        for (int b = 0; b < 4; b++) begin
            new_word_s[8*b +: 8] = ww_be[b] ? ww_data[8*b +: 8] : old_word_s[8*b +: 8];
        end
    end

    // Valid/dirty state; the only part of the array cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_r <= {LINES{1'b0}};
            dirty_r <= {LINES{1'b0}};
        end else begin
            if (lw_en) begin
                valid_r[lw_idx] <= 1'b1;
                dirty_r[lw_idx] <= 1'b0;
            end
            if (dc_en) begin
                dirty_r[dc_idx] <= 1'b0;
            end
            if (ww_en) begin
                dirty_r[ww_idx] <= 1'b1;
            end
        end
    end

    // Tag and line data storage; a line install takes priority over a word store.
    always_ff @(posedge CLK) begin
        if (lw_en) begin
            data_r[lw_idx] <= lw_data;
            tag_r[lw_idx]  <= lw_tag;
        end else if (ww_en) begin
            data_r[ww_idx][{ww_off, 5'd0} +: WORD_W] <= new_word_s;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache.
//   CPU side : cpu_re/cpu_we/cpu_addr/cpu_wdata/cpu_be in, cpu_rdata/cpu_ready out.
//              Hits answer combinationally in IDLE; a miss stalls cpu_ready low.
//   Adapter  : cla_re (fill) / cla_we (write-back) with cla_addr (line address),
//              cla_wline out; cla_rline/cla_ready in (ready is a one-cycle pulse).
//   CLK, RST : all state on posedge; RST is synchronous, active-high.
//   A miss is serviced IDLE -> [WRITEBACK] -> ALLOCATE -> REFILL -> IDLE, after
//   which the still-held request hits.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         cpu_re,
    input  logic                         cpu_we,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    input  logic [3:0]                   cpu_be,
    output logic [31:0]                  cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cla_re,
    output logic                         cla_we,
    output logic [26:0]                  cla_addr,
    output logic [LINE_WORDS*WORD_W-1:0] cla_wline,
    input  logic [LINE_WORDS*WORD_W-1:0] cla_rline,
    input  logic                         cla_ready
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_B = LINE_ADDR_W - IDX_W;

    dcache_state_t          state_r;
    logic [LINE_ADDR_W-1:0] miss_line_r;

    logic [LINE_ADDR_W-1:0] cpu_line_s;
    logic [IDX_W-1:0]       cpu_idx_s;
    logic [TAG_B-1:0]       cpu_tag_s;
    logic [OFF_W-1:0]       cpu_off_s;
    logic [IDX_W-1:0]       miss_idx_s;
    logic [TAG_B-1:0]       miss_tag_s;
    logic                   req_s;
    logic                   hit_s;
    logic                   ww_en_s;
    logic                   lw_en_s;
    logic                   dc_en_s;
    logic                   rd_valid_s;
    logic                   rd_dirty_s;
    logic [TAG_B-1:0]       rd_tag_s;
    logic [LINE_W-1:0]      rd_data_s;
    logic                   unused_s;

    assign unused_s = ^cpu_addr[1:0];

    // Split the CPU address and the latched miss line into their fields.
    always_comb begin
        cpu_line_s = addr_line(cpu_addr);
        cpu_idx_s  = cpu_line_s[IDX_W-1:0];
        cpu_tag_s  = cpu_line_s[LINE_ADDR_W-1:IDX_W];
        cpu_off_s  = addr_off(cpu_addr);
        miss_idx_s = miss_line_r[IDX_W-1:0];
        miss_tag_s = miss_line_r[LINE_ADDR_W-1:IDX_W];
    end

    // CPU response and array write strobes; a request with both re and we is a store.
    always_comb begin
        req_s     = cpu_re | cpu_we;
        hit_s     = rd_valid_s & (rd_tag_s == cpu_tag_s);
        cpu_ready = 1'b0;
        cpu_rdata = 32'h0000_0000;
        ww_en_s   = 1'b0;
        lw_en_s   = 1'b0;
        dc_en_s   = 1'b0;
        if (RST) begin
            cpu_ready = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && hit_s) begin
                        cpu_ready = 1'b1;
                        ww_en_s   = cpu_we;
                        cpu_rdata = cpu_we ? 32'h0000_0000 : rd_data_s[{cpu_off_s, 5'd0} +: WORD_W];
                    end else begin
                        cpu_ready = 1'b0;
                    end
                end
                WRITEBACK: dc_en_s = cla_ready;
                ALLOCATE:  lw_en_s = cla_ready;
                REFILL:    cpu_ready = 1'b0;
                default:   cpu_ready = 1'b0;
            endcase
        end
    end

    // Miss-handling FSM; adapter-side outputs are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            miss_line_r <= {LINE_ADDR_W{1'b0}};
            cla_re      <= 1'b0;
            cla_we      <= 1'b0;
            cla_addr    <= 27'h0;
            cla_wline   <= {LINE_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && !hit_s) begin
                        // Latch the line so the fill completes even if the CPU drops the request.
                        miss_line_r <= cpu_line_s;
                        if (rd_dirty_s) begin
                            state_r   <= WRITEBACK;
                            cla_we    <= 1'b1;
                            cla_addr  <= {rd_tag_s, cpu_idx_s};
                            cla_wline <= rd_data_s;
                        end else begin
                            state_r  <= ALLOCATE;
                            cla_re   <= 1'b1;
                            cla_addr <= cpu_line_s;
                        end
                    end
                end
                WRITEBACK: begin
                    if (cla_ready) begin
                        state_r   <= ALLOCATE;
                        cla_we    <= 1'b0;
                        cla_re    <= 1'b1;
                        cla_addr  <= miss_line_r;
                        cla_wline <= {LINE_W{1'b0}};
                    end
                end
                ALLOCATE: begin
                    if (cla_ready) begin
                        state_r  <= REFILL;
                        cla_re   <= 1'b0;
                        cla_addr <= 27'h0;
                    end
                end
                REFILL: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    cla_re    <= 1'b0;
                    cla_we    <= 1'b0;
                    cla_addr  <= 27'h0;
                    cla_wline <= {LINE_W{1'b0}};
                end
            endcase
        end
    end

    cache_line_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_B (TAG_B)
    ) u_ram (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (cpu_idx_s),
        .rd_valid (rd_valid_s),
        .rd_dirty (rd_dirty_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .ww_en    (ww_en_s),
        .ww_idx   (cpu_idx_s),
        .ww_off   (cpu_off_s),
        .ww_be    (cpu_be),
        .ww_data  (cpu_wdata),
        .lw_en    (lw_en_s),
        .lw_idx   (miss_idx_s),
        .lw_tag   (miss_tag_s),
        .lw_data  (cla_rline),
        .dc_en    (dc_en_s),
        .dc_idx   (miss_idx_s)
    );

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scenarios followed by random loads/stores, checked
// against an architectural memory model (coh), a backing-store model (mem)
// and a per-index residency/dirty model used to predict latency and traffic.
module tb_dcache_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         cpu_re;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_be;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cla_re;
    logic         cla_we;
    logic [26:0]  cla_addr;
    logic [255:0] cla_wline;
    logic [255:0] cla_rline;
    logic         cla_ready;

    always #5 CLK = ~CLK;

    dcache_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cla_re    (cla_re),
        .cla_we    (cla_we),
        .cla_addr  (cla_addr),
        .cla_wline (cla_wline),
        .cla_rline (cla_rline),
        .cla_ready (cla_ready)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [255:0] mem [int];   // adapter-side memory
    logic [255:0] coh [int];   // architecturally visible memory
    bit           mvalid [16];
    bit           mdirty [16];
    int           mtag   [16];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic touch(input int la);
        if (!mem.exists(la)) begin
            mem[la] = rnd_line();
            coh[la] = mem[la];
        end
    endtask

    // Reset discards cached contents: dirty data is lost.
    task automatic model_reset();
        foreach (mem[k]) coh[k] = mem[k];
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = 0;
        end
    endtask

    // One CPU access with an adapter that answers after lat cycles.
    task automatic access(input logic [31:0] addr, input bit re, input bit we,
                          input logic [31:0] wdata, input logic [3:0] be, input int lat);
        int la, idx, tg, off, n, cnt, exp_n, va;
        bit exp_hit, exp_wb, seen_re, seen_we, done;
        logic [31:0]  word;
        logic [255:0] line_v;
        la  = int'(addr >> 5);
        idx = la % 16;
        tg  = la / 16;
        off = int'(addr[4:2]);
        exp_hit = mvalid[idx] && (mtag[idx] == tg);
        exp_wb  = !exp_hit && mdirty[idx];
        exp_n   = exp_hit ? 0 : (exp_wb ? 2*lat + 2 : lat + 2);
        va      = mtag[idx]*16 + idx;
        touch(la);
        cpu_addr = addr; cpu_re = re; cpu_we = we; cpu_wdata = wdata; cpu_be = be;
        n = 0; cnt = 0; done = 1'b0; seen_re = 1'b0; seen_we = 1'b0;
        while (!done && n < 100) begin
            #1;
            chk("re_we_excl", cla_re & cla_we, 1'b0);
            cla_ready = 1'b0;
            cla_rline = rnd_line();
            if (cpu_ready) begin
                done = 1'b1;
                chk("latency", n, exp_n);
                line_v = coh[la];
                if (re && !we) chk("rdata", cpu_rdata, line_v[32*off +: 32]);
                else chk("rdata_store", cpu_rdata, 32'h0);
            end else if (cla_we) begin
                if (!seen_we) begin
                    chk("wb_addr", cla_addr, va);
                    chk("wb_line", cla_wline, coh.exists(va) ? coh[va] : 256'h0);
                end
                seen_we = 1'b1;
                cnt++;
                if (cnt == lat) begin cla_ready = 1'b1; cnt = 0; end
            end else if (cla_re) begin
                if (!seen_re) chk("fill_addr", cla_addr, la);
                seen_re = 1'b1;
                cnt++;
                if (cnt == lat) begin cla_ready = 1'b1; cla_rline = mem[la]; cnt = 0; end
            end
            @(posedge CLK);
            @(negedge CLK);
            if (!done) n++;
        end
        chk("completed", done, 1'b1);
        chk("saw_wb", seen_we, exp_wb);
        chk("saw_fill", seen_re, !exp_hit);
        cpu_re = 1'b0; cpu_we = 1'b0; cla_ready = 1'b0;
        #1;
        chk("idle_outs", {cpu_ready, cla_re, cla_we}, 3'b000);
        if (!exp_hit) begin
            if (exp_wb) mem[va] = coh[va];
            mvalid[idx] = 1'b1; mtag[idx] = tg; mdirty[idx] = 1'b0;
        end
        if (we) begin
            mdirty[idx] = 1'b1;
            line_v = coh[la];
            word   = line_v[32*off +: 32];
            for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
            line_v[32*off +: 32] = word;
            coh[la] = line_v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l;
        logic [31:0]  a_v;
        logic [3:0]   be_v;
        int n, op;
        RST = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        cpu_be = 4'h0; cla_rline = 256'h0; cla_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_ctrl", {cpu_ready, cla_re, cla_we}, 3'b000);
        chk("rst_addr", cla_addr, 27'h0);
        chk("rst_wline", cla_wline, 256'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Clean miss fill returning 0xDEADBEEF in word 0 of line 0x2.
        touch(2);
        l = mem[2]; l[31:0] = 32'hDEAD_BEEF; mem[2] = l; coh[2] = l;
        access(32'h0000_0040, 1'b1, 1'b0, 32'h0, 4'h0, 3);
        // Partial store hit then reload of the merged word.
        access(32'h0000_0044, 1'b0, 1'b1, 32'h1234_5678, 4'b0011, 2);
        access(32'h0000_0044, 1'b1, 1'b0, 32'h0, 4'h0, 2);
        // Conflicting tag at index 2: dirty write-back then fill of line 0x12.
        access(32'h0000_0240, 1'b1, 1'b0, 32'h0, 4'h0, 2);

        // Reset while the fill is outstanding.
        touch(32'h80);
        cpu_addr = 32'h0000_1000; cpu_re = 1'b1; cpu_we = 1'b0;
        n = 0;
        #1;
        while (!cla_re && n < 20) begin
            @(posedge CLK); @(negedge CLK); #1; n++;
        end
        chk("alloc_reached", cla_re, 1'b1);
        RST = 1'b1; cpu_re = 1'b0;
        @(posedge CLK); @(negedge CLK); #1;
        chk("rst_mid_re", cla_re, 1'b0);
        chk("rst_mid_ready", cpu_ready, 1'b0);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        access(32'h0000_0240, 1'b1, 1'b0, 32'h0, 4'h0, 1);

        // re and we together act as a store; stray cla_ready while idle is ignored.
        access(32'h0000_0080, 1'b1, 1'b0, 32'h0, 4'h0, 2);
        access(32'h0000_0080, 1'b1, 1'b1, 32'hA5C3_0F96, 4'hF, 2);
        cla_rline = rnd_line(); cla_ready = 1'b1;
        @(posedge CLK); @(negedge CLK);
        cla_ready = 1'b0; #1;
        chk("stray_ready", {cpu_ready, cla_re, cla_we}, 3'b000);
        access(32'h0000_0080, 1'b1, 1'b0, 32'h0, 4'h0, 2);
        access(32'h0000_0280, 1'b1, 1'b0, 32'h0, 4'h0, 3);

        // Random traffic over 4 indices x 4 tags.
        for (int i = 0; i < 250; i++) begin
            a_v  = 32'($urandom_range(0, 3) * 512 + $urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4);
            be_v = 4'($urandom_range(0, 15));
            op   = $urandom_range(0, 2);
            access(a_v, op != 1, op != 0, $urandom, be_v, $urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
